// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake and instruction-memory write bus for imem_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   logic        RX_READY;
   logic        IMEM_WE;
   logic [31:0] IMEM_A;
   logic [31:0] IMEM_WD;
   logic        CPU_RST;
   logic        DONE;
   logic        ERR;

   modport slave (
      input  RX_DATA, RX_VALID,
      output RX_READY, IMEM_WE, IMEM_A, IMEM_WD, CPU_RST, DONE, ERR
   );

   modport master (
      output RX_DATA, RX_VALID,
      input  RX_READY, IMEM_WE, IMEM_A, IMEM_WD, CPU_RST, DONE, ERR
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Framed byte-stream boot loader for instruction memory; holds the core in reset until a good frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int         DEPTH_WORDS = 64,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  wire logic     CLK,
   input  wire logic     RST_N,
   imem_loader_if.slave  lb
);

   localparam logic [15:0] c_DEPTH = 16'(DEPTH_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CNT_HI = 3'd1,
      CNT_LO = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4
   } state_t;

   state_t      r_state, w_nstate;
   logic [15:0] r_cnt, w_ncnt;
   logic [15:0] r_widx, w_nwidx;
   logic [1:0]  r_bidx, w_nbidx;
   logic [23:0] r_word, w_nword;
   logic [7:0]  r_csum, w_ncsum;
   logic        r_we, w_nwe;
   logic [31:0] r_addr, w_naddr;
   logic [31:0] r_wd, w_nwd;
   logic        r_cpu_rst, w_ncpu_rst;
   logic        r_done, w_ndone;
   logic        r_err, w_nerr;
   logic        r_ready;

   logic        w_fire;
   logic [15:0] w_count;
   logic [15:0] w_widx_inc;

   assign w_fire     = lb.RX_VALID && r_ready;
   assign w_count    = {r_cnt[15:8], lb.RX_DATA};
   assign w_widx_inc = r_widx + 16'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_widx    <= '0;
         r_bidx    <= '0;
         r_word    <= '0;
         r_csum    <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wd      <= '0;
         r_cpu_rst <= 1'b1;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_cnt     <= w_ncnt;
         r_widx    <= w_nwidx;
         r_bidx    <= w_nbidx;
         r_word    <= w_nword;
         r_csum    <= w_ncsum;
         r_we      <= w_nwe;
         r_addr    <= w_naddr;
         r_wd      <= w_nwd;
         r_cpu_rst <= w_ncpu_rst;
         r_done    <= w_ndone;
         r_err     <= w_nerr;
         r_ready   <= 1'b1;
      end
   end

   always_comb begin
      w_nstate   = r_state;
      w_ncnt     = r_cnt;
      w_nwidx    = r_widx;
      w_nbidx    = r_bidx;
      w_nword    = r_word;
      w_ncsum    = r_csum;
      w_nwe      = 1'b0;
      w_naddr    = r_addr;
      w_nwd      = r_wd;
      w_ncpu_rst = r_cpu_rst;
      w_ndone    = r_done;
      w_nerr     = r_err;

      if (w_fire) begin
         case (r_state)
            IDLE: begin
               if (lb.RX_DATA == SYNC_BYTE) begin
                  w_nstate   = CNT_HI;
                  w_ncpu_rst = 1'b1;
                  w_ndone    = 1'b0;
                  w_nerr     = 1'b0;
                  w_ncsum    = '0;
                  w_nwidx    = '0;
                  w_nbidx    = '0;
               end
            end
            CNT_HI: begin
               w_ncnt   = {lb.RX_DATA, 8'h00};
               w_nstate = CNT_LO;
            end
            CNT_LO: begin
               w_ncnt = w_count;
               if (w_count > c_DEPTH) begin
                  w_nerr   = 1'b1;
                  w_nstate = IDLE;
               end else if (w_count == 16'd0) begin
                  w_nstate = CHK;
               end else begin
                  w_nstate = DATA;
               end
            end
            DATA: begin
               w_ncsum = r_csum ^ lb.RX_DATA;
               w_nbidx = r_bidx + 2'd1;
               case (r_bidx)
                  2'd0: w_nword[7:0]   = lb.RX_DATA;
                  2'd1: w_nword[15:8]  = lb.RX_DATA;
                  2'd2: w_nword[23:16] = lb.RX_DATA;
                  default: begin
                     // Last byte goes straight into the write data; the word buffer is not needed for it.
                     w_nwe   = 1'b1;
                     w_nwd   = {lb.RX_DATA, r_word};
                     w_naddr = {14'd0, r_widx, 2'b00};
                     w_nwidx = w_widx_inc;
                     w_nbidx = 2'd0;
                     if (w_widx_inc == r_cnt) begin
                        w_nstate = CHK;
                     end
                  end
               endcase
            end
            CHK: begin
               if (lb.RX_DATA == r_csum) begin
                  w_ndone    = 1'b1;
                  w_ncpu_rst = 1'b0;
               end else begin
                  w_nerr = 1'b1;
               end
               w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
         endcase
      end
   end

   assign lb.RX_READY = r_ready;
   assign lb.IMEM_WE  = r_we;
   assign lb.IMEM_A   = r_addr;
   assign lb.IMEM_WD  = r_wd;
   assign lb.CPU_RST  = r_cpu_rst;
   assign lb.DONE     = r_done;
   assign lb.ERR      = r_err;

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch path reads through `PC`. It accepts a framed byte stream (sync, word count, little-endian instruction words, XOR checksum) over a valid/ready handshake, and assembles each group of four bytes into a 32-bit word. Each word is written to consecutive word-aligned byte addresses starting at 0. The core is held in reset through `CPU_RST` until a frame completes with a good checksum.

## Interface
- `DEPTH_WORDS`, 64: instruction memory capacity in words; the largest accepted word count.
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `CLK` in 1: clock; all logic on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `RX_DATA` in 8: incoming byte.
- `RX_VALID` in 1: `RX_DATA` is valid.
- `RX_READY` out 1: loader accepts a byte; a byte transfers on a cycle where `RX_VALID` and `RX_READY` are both 1.
- `IMEM_WE` out 1: one-cycle write strobe to instruction memory.
- `IMEM_A` out 32: byte address of the write, always a multiple of 4.
- `IMEM_WD` out 32: write data.
- `CPU_RST` out 1: active-high reset to the core, matching the core's `RST`.
- `DONE` out 1: the last frame loaded successfully.
- `ERR` out 1: the last frame was rejected.

## Operation
- Reset values:
  - `RX_READY`=0, `IMEM_WE`=0, `IMEM_A`=0, `IMEM_WD`=0.
  - `CPU_RST`=1, `DONE`=0, `ERR`=0.
  - State IDLE.
- `RX_READY`=1 in every state once out of reset. The loader never back-pressures.
- States and transitions:
  - IDLE:
    - Accepted bytes other than `SYNC_BYTE` are discarded.
    - On an accepted `SYNC_BYTE`: go to CNT_HI, set `CPU_RST`=1, clear `DONE` and `ERR`, clear checksum, word index and byte index.
  - CNT_HI: the accepted byte is count[15:8]; go to CNT_LO.
  - CNT_LO: the accepted byte is count[7:0].
    - count > `DEPTH_WORDS`: set `ERR`=1 and go to IDLE.
    - count == 0: go to CHK.
    - Otherwise: go to DATA.
  - DATA:
    - Byte k (0..3) of the current word is placed at bits [8k+7:8k], little-endian, and XORed into the checksum.
    - After byte 3 is accepted, the assembled word is registered into `IMEM_WD`, `IMEM_A` = 4 × word index, and `IMEM_WE` pulses for one cycle.
    - The word index then increments and the byte index returns to 0.
    - When the word index reaches count, go to CHK.
  - CHK: compare the accepted byte with the checksum (XOR of all data bytes; 8'h00 when count is 0).
    - Equal: set `DONE`=1, set `CPU_RST`=0, go to IDLE.
    - Not equal: set `ERR`=1, keep `CPU_RST`=1, go to IDLE.
- A sync byte seen in CNT_HI, CNT_LO, DATA or CHK is treated as ordinary data. There is no resynchronisation mid-frame.
- Reload: a new `SYNC_BYTE` in IDLE after `DONE` reasserts `CPU_RST` and starts a fresh load.
- `DONE` and `ERR` stay set until the next accepted `SYNC_BYTE`. They are never both 1.
- Word index and count registers are 16 bits wide. The comparison with `DEPTH_WORDS` uses the full 16-bit count.

## Timing
- The write strobe is registered. `IMEM_WE`, `IMEM_A` and `IMEM_WD` are valid in the cycle after the handshake of byte 3 of a word.
- `IMEM_A` and `IMEM_WD` hold their value until the next write.
- Back-to-back bytes: the earliest next word write comes 4 cycles after the previous one. The next word's byte 0 may be accepted in the same cycle as the previous `IMEM_WE`.
- `DONE` and `CPU_RST` deassertion occur in the cycle after the checksum byte handshake. `ERR` likewise, or the cycle after the count-low handshake for an oversize count.
- `CPU_RST` rises in the cycle after the sync byte handshake.
- Gaps in `RX_VALID` stall the FSM in its current state with all internal state held.
- `RST_N` low at any time, mid-frame included, immediately forces all reset values. No partial write completes: `IMEM_WE` drops asynchronously.

## Test plan
- Frame A5 00 02 | 24 08 00 05 | 8C 09 00 04 | checksum A8:
  - `IMEM_WE` pulses twice: address 0 with data 0x05000824, then address 4 with data 0x0400098C.
  - `DONE`=1, `CPU_RST`=0, `ERR`=0.
- Same frame with checksum 00: both writes occur, then `ERR`=1, `DONE`=0, `CPU_RST` stays 1.
- Garbage bytes 00 FF 5A, then A5 00 00 00: no writes; `DONE`=1 and `CPU_RST`=0 one cycle after the last byte.
- A5 00 41 with `DEPTH_WORDS`=64: `ERR`=1 right after the count-low byte, no writes. A following valid frame loads normally and clears `ERR`.
- Frame A with `RX_VALID` toggled randomly: identical writes and outputs to the gap-free run.
- Reset mid-frame: `RST_N` pulsed low after byte 2 of word 1 → all outputs return to reset values with no write to address 4. A following full frame A loads both words correctly.
